wb_arbiter: RTL and testbench

Writeback arbiter for the Raisin64 core. It collects completed results from the execution units and serialises them onto the single register-file write port. On that same port it drives the free (busy-clear) request into the pending register table. Each unit gets a one-entry holding buffer, and grants rotate round-robin so no unit starves.

---
 rtl/raisin64_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 55 +++++
 rtl/wb_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raisin64_pkg.sv
// raisin64_pkg: constants and encodings shared across the Raisin64 core.
//   RN_W      - register-number width (pending table, register file, writeback)
//   DATA_W    - datapath/result width
//   NUM_EU    - number of execution units that feed writeback
//   unit_e    - execution-unit index encoding used for writeback slots
package raisin64_pkg;

   localparam int unsigned RN_W   = 7;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned NUM_EU = 4;

   typedef enum logic [1:0] {
      UnitAlu0   = 2'd0,
      UnitAlu1   = 2'd1,
      UnitMem    = 2'd2,
      UnitMulDiv = 2'd3
   } unit_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered last-grant pointer.
//   clk        in   core clock
//   rst_n      in   asynchronous active-low reset
//   req        in   N request lines
//   advance    in   commit the current grant (moves the pointer)
//   grant      out  one-hot grant, combinational from req and pointer
//   grant_idx  out  binary index of the granted requester
module rr_arbiter #(
   parameter int unsigned N = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] r_last;
   logic [IW-1:0] w_k;
   logic [IW-1:0] w_idx;
   logic [N-1:0]  w_grant;
   logic          w_found;

   // Search starts one past the last winner and wraps, so the last winner
   // is the lowest priority this cycle.
   always_comb begin
      w_grant = '0;
      w_idx   = '0;
      w_found = 1'b0;
      w_k     = '0;
      for (int unsigned off = 1; off <= N; off++) begin
         w_k = IW'((32'(r_last) + off) % N);
         if (!w_found && req[w_k]) begin
            w_found        = 1'b1;
            w_idx          = w_k;
            w_grant[w_k]   = 1'b1;
         end
      end
   end

   // Reset pointer to N-1 so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= IW'(N - 1);
      end else if (advance && w_found) begin
         r_last <= w_idx;
      end
   end

   assign grant     = w_grant;
   assign grant_idx = w_idx;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter. Each execution unit has a one-entry holding
// buffer; held entries are granted round-robin onto the single register-file
// write port, which also drives the pending-table free request.
//   clk       in   core clock
//   rst_n     in   asynchronous active-low reset
//   eu_valid  in   per-unit result valid
//   eu_rn     in   per-unit destination register, unit i at [i*RN_W +: RN_W]
//   eu_data   in   per-unit result, unit i at [i*DATA_W +: DATA_W]
//   eu_ready  out  per-unit holding buffer can accept this cycle
//   rf_we     out  register-file write enable (registered)
//   rf_rn     out  register-file write address (registered)
//   rf_data   out  register-file write data (registered)
//   free_rn   out  pending-table free register, 0 when no write (registered)
module wb_arbiter
   import raisin64_pkg::*;
#(
   parameter int unsigned NUM_UNITS = NUM_EU,
   parameter int unsigned DATA_W    = raisin64_pkg::DATA_W,
   parameter int unsigned RN_W      = raisin64_pkg::RN_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_UNITS-1:0]        eu_valid,
   input  logic [NUM_UNITS*RN_W-1:0]   eu_rn,
   input  logic [NUM_UNITS*DATA_W-1:0] eu_data,
   output logic [NUM_UNITS-1:0]        eu_ready,
   output logic                        rf_we,
   output logic [RN_W-1:0]             rf_rn,
   output logic [DATA_W-1:0]           rf_data,
   output logic [RN_W-1:0]             free_rn
);

   localparam int unsigned IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   logic [NUM_UNITS-1:0] w_held;
   logic [NUM_UNITS-1:0] w_grant;
   logic [NUM_UNITS-1:0] w_ready;
   logic [NUM_UNITS-1:0] w_load;
   logic [IW-1:0]        w_grant_idx;
   logic                 w_any_grant;
   logic [RN_W-1:0]      w_rn   [NUM_UNITS];
   logic [DATA_W-1:0]    w_data [NUM_UNITS];
   logic [RN_W-1:0]      w_sel_rn;
   logic [DATA_W-1:0]    w_sel_data;

   logic                 r_rf_we;
   logic [RN_W-1:0]      r_rf_rn;
   logic [DATA_W-1:0]    r_rf_data;
   logic [RN_W-1:0]      r_free_rn;

   // A granted slot drains at this edge, so it may refill at the same edge.
   assign w_ready  = ~w_held | w_grant;
   assign w_load   = eu_valid & w_ready;
   assign eu_ready = w_ready;

   rr_arbiter #(
      .N (NUM_UNITS)
   ) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (w_held),
      .advance   (w_any_grant),
      .grant     (w_grant),
      .grant_idx (w_grant_idx)
   );

   assign w_any_grant = |w_grant;

   for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_buf
      logic              r_held;
      logic [RN_W-1:0]   r_rn;
      logic [DATA_W-1:0] r_data;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_held <= 1'b0;
            r_rn   <= '0;
            r_data <= '0;
         end else if (w_load[gi]) begin
            r_held <= 1'b1;
            r_rn   <= eu_rn[gi*RN_W +: RN_W];
            r_data <= eu_data[gi*DATA_W +: DATA_W];
         end else if (w_grant[gi]) begin
            r_held <= 1'b0;
         end
      end

      assign w_held[gi] = r_held;
      assign w_rn[gi]   = r_rn;
      assign w_data[gi] = r_data;
   end

   assign w_sel_rn   = w_rn[w_grant_idx];
   assign w_sel_data = w_data[w_grant_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rf_we   <= 1'b0;
         r_rf_rn   <= '0;
         r_rf_data <= '0;
         r_free_rn <= '0;
      end else if (w_any_grant) begin
         // Register 0 results drain silently: no write, and free_rn is
         // already 0 because the selected rn is 0.
         r_rf_we   <= (w_sel_rn != '0);
         r_rf_rn   <= w_sel_rn;
         r_rf_data <= w_sel_data;
         r_free_rn <= w_sel_rn;
      end else begin
         r_rf_we   <= 1'b0;
         r_free_rn <= '0;
      end
   end

   assign rf_we   = r_rf_we;
   assign rf_rn   = r_rf_rn;
   assign rf_data = r_rf_data;
   assign free_rn = r_free_rn;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic for wb_arbiter,
// checked every cycle against a behavioural model of the holding buffers,
// the rotating-priority search and the one-cycle output register.
module tb_wb_arbiter;
   import raisin64_pkg::*;

   localparam int N  = 4;
   localparam int RW = 7;
   localparam int DW = 64;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    eu_valid;
   logic [N*RW-1:0] eu_rn;
   logic [N*DW-1:0] eu_data;
   logic [N-1:0]    eu_ready;
   logic            rf_we;
   logic [RW-1:0]   rf_rn;
   logic [DW-1:0]   rf_data;
   logic [RW-1:0]   free_rn;

   always #5 clk = ~clk;

   wb_arbiter #(
      .NUM_UNITS (N),
      .DATA_W    (DW),
      .RN_W      (RW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .eu_valid (eu_valid),
      .eu_rn    (eu_rn),
      .eu_data  (eu_data),
      .eu_ready (eu_ready),
      .rf_we    (rf_we),
      .rf_rn    (rf_rn),
      .rf_data  (rf_data),
      .free_rn  (free_rn)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: slot contents, rotating pointer, pending output write.
   bit            m_held  [N];
   logic [RW-1:0] m_rn    [N];
   logic [DW-1:0] m_data  [N];
   bit            m_acc   [N];
   bit            m_stall [N];
   int            m_last;
   bit            m_we;
   logic [RW-1:0] m_orn;
   logic [RW-1:0] m_free;
   logic [DW-1:0] m_odata;
   bit            chk_en = 1'b0;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_held[i]  = 1'b0;
         m_acc[i]   = 1'b0;
         m_stall[i] = 1'b0;
      end
      m_last  = N - 1;
      m_we    = 1'b0;
      m_orn   = '0;
      m_free  = '0;
      m_odata = '0;
   endfunction

   function automatic int find_grant();
      for (int off = 1; off <= N; off++) begin
         if (m_held[(m_last + off) % N]) return (m_last + off) % N;
      end
      return -1;
   endfunction

   // Compare process: check current outputs, then advance the model across
   // the coming rising edge using the inputs that edge will see.
   always @(negedge clk) begin
      if (chk_en) begin
         if (!rst_n) begin
            model_reset();
            check("rst_eu_ready", 64'(eu_ready), 64'({N{1'b1}}));
            check("rst_rf_we", 64'(rf_we), 64'd0);
            check("rst_free_rn", 64'(free_rn), 64'd0);
            check("rst_rf_rn", 64'(rf_rn), 64'd0);
            check("rst_rf_data", rf_data, 64'd0);
         end else begin
            int g;
            logic [N-1:0] rdy;
            g = find_grant();
            for (int i = 0; i < N; i++) rdy[i] = !m_held[i] || (g == i);
            check("eu_ready", 64'(eu_ready), 64'(rdy));
            check("rf_we", 64'(rf_we), 64'(m_we));
            check("free_rn", 64'(free_rn), 64'(m_free));
            if (m_we) begin
               check("rf_rn", 64'(rf_rn), 64'(m_orn));
               check("rf_data", rf_data, m_odata);
            end
            if (g >= 0) begin
               m_orn   = m_rn[g];
               m_odata = m_data[g];
               m_we    = (m_rn[g] != '0);
               m_free  = m_we ? m_rn[g] : '0;
               m_last  = g;
            end else begin
               m_we   = 1'b0;
               m_free = '0;
            end
            for (int i = 0; i < N; i++) begin
               m_acc[i]   = eu_valid[i] && rdy[i];
               m_stall[i] = eu_valid[i] && !rdy[i];
               if (m_acc[i]) begin
                  m_held[i] = 1'b1;
                  m_rn[i]   = eu_rn[i*RW +: RW];
                  m_data[i] = eu_data[i*DW +: DW];
               end else if (g == i) begin
                  m_held[i] = 1'b0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_unit(input int i, input bit v, input logic [RW-1:0] rn,
                           input logic [DW-1:0] d);
      eu_valid[i]          = v;
      eu_rn[i*RW +: RW]    = rn;
      eu_data[i*DW +: DW]  = d;
   endtask

   task automatic idle(input int n);
      eu_valid = '0;
      repeat (n) tick();
   endtask

   logic [DW-1:0] cnt;
   logic [RW-1:0] prev_rn;
   bit            prev_we;
   int            n0, n1, p;
   logic [RW-1:0] rrn;

   initial begin
      rst_n    = 1'b0;
      eu_valid = '0;
      eu_rn    = '0;
      eu_data  = '0;
      #2;
      check("init_eu_ready", 64'(eu_ready), 64'hF);
      check("init_rf_we", 64'(rf_we), 64'd0);
      check("init_rf_rn", 64'(rf_rn), 64'd0);
      check("init_rf_data", rf_data, 64'd0);
      check("init_free_rn", 64'(free_rn), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      chk_en = 1'b1;

      // Simultaneous 4-way: rn 1..4 written on four consecutive cycles.
      for (int i = 0; i < N; i++) set_unit(i, 1'b1, RW'(i + 1), 64'h1000 + 64'(i));
      tick();
      eu_valid = '0;
      for (int k = 1; k <= 5; k++) begin
         if (k <= 4) check("four_way_ready3", 64'(eu_ready[3]), 64'(k == 4));
         if (k >= 2) begin
            check("four_way_we", 64'(rf_we), 64'd1);
            check("four_way_rn", 64'(rf_rn), 64'(k - 1));
         end
         tick();
      end
      idle(3);

      // Single result from the MEM unit.
      set_unit(int'(UnitMem), 1'b1, 7'd5, 64'hDEAD_BEEF);
      tick();
      eu_valid = '0;
      check("single_t1_we", 64'(rf_we), 64'd0);
      tick();
      check("single_we", 64'(rf_we), 64'd1);
      check("single_rn", 64'(rf_rn), 64'd5);
      check("single_data", rf_data, 64'hDEAD_BEEF);
      check("single_free", 64'(free_rn), 64'd5);
      tick();
      check("single_t3_we", 64'(rf_we), 64'd0);
      check("single_t3_free", 64'(free_rn), 64'd0);
      idle(2);

      // Register 0 result drains without a write.
      set_unit(int'(UnitAlu1), 1'b1, 7'd0, 64'h1234);
      tick();
      eu_valid = '0;
      check("r0_t1_we", 64'(rf_we), 64'd0);
      tick();
      check("r0_t2_ready1", 64'(eu_ready[1]), 64'd1);
      check("r0_t2_we", 64'(rf_we), 64'd0);
      check("r0_t2_free", 64'(free_rn), 64'd0);
      tick();
      check("r0_t3_we", 64'(rf_we), 64'd0);
      idle(2);

      // Refill on grant: unit 0 reloads in the same cycle it is granted.
      set_unit(int'(UnitAlu0), 1'b1, 7'd7, 64'hAAAA);
      tick();
      set_unit(int'(UnitAlu0), 1'b1, 7'd8, 64'hBBBB);
      check("refill_ready0", 64'(eu_ready[0]), 64'd1);
      tick();
      eu_valid = '0;
      check("refill_a_we", 64'(rf_we), 64'd1);
      check("refill_a_rn", 64'(rf_rn), 64'd7);
      check("refill_a_data", rf_data, 64'hAAAA);
      tick();
      check("refill_b_we", 64'(rf_we), 64'd1);
      check("refill_b_rn", 64'(rf_rn), 64'd8);
      check("refill_b_data", rf_data, 64'hBBBB);
      tick();
      check("refill_done_we", 64'(rf_we), 64'd0);
      idle(2);

      // Fairness: units 0 and 1 stream back to back.
      cnt = 64'h5000;
      set_unit(0, 1'b1, 7'd10, cnt);
      cnt++;
      set_unit(1, 1'b1, 7'd20, cnt);
      cnt++;
      prev_we = 1'b0;
      prev_rn = '0;
      n0 = 0;
      n1 = 0;
      for (int c = 0; c < 24; c++) begin
         tick();
         if (rf_we && prev_we) check("rr_alternate", 64'(rf_rn != prev_rn), 64'd1);
         if (rf_we && rf_rn == 7'd10) n0++;
         if (rf_we && rf_rn == 7'd20) n1++;
         prev_we = rf_we;
         prev_rn = rf_rn;
         for (int i = 0; i < 2; i++) begin
            if (m_acc[i]) begin
               eu_data[i*DW +: DW] = cnt;
               cnt++;
            end
         end
      end
      check("rr_balance", 64'((n0 - n1 <= 1) && (n1 - n0 <= 1) && (n0 > 8)), 64'd1);
      for (int c = 0; c < 4; c++) begin
         tick();
         for (int i = 0; i < 2; i++) if (m_acc[i]) eu_valid[i] = 1'b0;
      end
      idle(3);

      // Reset while three entries are held.
      set_unit(1, 1'b1, 7'd31, 64'h31);
      set_unit(2, 1'b1, 7'd32, 64'h32);
      set_unit(3, 1'b1, 7'd33, 64'h33);
      tick();
      eu_valid = '0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_eu_ready", 64'(eu_ready), 64'hF);
      check("midrst_rf_we", 64'(rf_we), 64'd0);
      check("midrst_free_rn", 64'(free_rn), 64'd0);
      check("midrst_rf_rn", 64'(rf_rn), 64'd0);
      check("midrst_rf_data", rf_data, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("no_stale_we", 64'(rf_we), 64'd0);
      end

      // Randomized traffic; stalled units keep presenting the same result.
      p = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) p = $urandom_range(10, 95);
         for (int i = 0; i < N; i++) begin
            if (!m_stall[i]) begin
               if ($urandom_range(0, 99) < p) begin
                  rrn = ($urandom_range(0, 7) == 0) ? 7'd0 : RW'($urandom_range(1, 127));
                  set_unit(i, 1'b1, rrn, {$urandom, $urandom});
               end else begin
                  eu_valid[i] = 1'b0;
               end
            end
         end
         tick();
      end
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
